interact_ctrl: RTL and testbench



---
 rtl/interact_ctrl_pkg.sv | 39 +++
 rtl/interact_ctrl_move_target.sv | 34 +++
 rtl/interact_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_interact_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interact_ctrl_pkg.sv
// interact_ctrl_pkg: shared definitions for the tile-interaction initiator.
//   - FSM state encoding
//   - move direction codes
//   - result codes
//   - default map size and the limits used by the commit wrap check
// Tile ids are not defined here. They come from the existing resource parameters.
package interact_ctrl_pkg;

  localparam int MAP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    RES_MOVED   = 2'd0,
    RES_BLOCKED = 2'd1,
    RES_EDGE    = 2'd2,
    RES_CANCEL  = 2'd3
  } result_t;

  // A key count at KEY_MAX that the resolver returns as 0 has wrapped.
  localparam logic [3:0] KEY_MAX = 4'd15;

  // A health near the top that the resolver returns as tiny has wrapped upward.
  localparam logic [7:0] HEALTH_WRAP_HI = 8'd251;
  localparam logic [7:0] HEALTH_WRAP_LO = 8'd5;

endpackage

// File: rtl/interact_ctrl_move_target.sv
// interact_ctrl_move_target: combinational target-cell calculator.
// Ports:
//   x, y     in  current position
//   dir      in  move direction (up y-1, down y+1, left x-1, right x+1)
//   tx, ty   out target position (equals x, y when at_edge is set)
//   at_edge  out the move would leave the map
module interact_ctrl_move_target #(
  parameter int MAP_W = interact_ctrl_pkg::MAP_W
) (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [1:0] dir,
  output logic [3:0] tx,
  output logic [3:0] ty,
  output logic       at_edge
);
  import interact_ctrl_pkg::*;

  localparam logic [3:0] LAST = 4'(MAP_W - 1);

  always_comb begin
    tx      = x;
    ty      = y;
    at_edge = 1'b0;
    case (dir_t'(dir))
      DIR_UP:    if (y == 4'd0) at_edge = 1'b1; else ty = y - 4'd1;
      DIR_DOWN:  if (y == LAST) at_edge = 1'b1; else ty = y + 4'd1;
      DIR_LEFT:  if (x == 4'd0) at_edge = 1'b1; else tx = x - 4'd1;
      DIR_RIGHT: if (x == LAST) at_edge = 1'b1; else tx = x + 4'd1;
      default:   at_edge = 1'b0;
    endcase
  end

endmodule

// File: rtl/interact_ctrl.sv
// interact_ctrl: sequential initiator for the tile-interaction resolver.
//
// A move is accepted in IDLE. The target cell is read from map RAM. Tile and
// player state are presented to the resolver, and its results are captured.
// Position, keys and health are then committed, and the replacement tile is
// written back.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   init, init_x/y/health       level-load strobe and start values (health 0 -> HEALTH_INIT)
//   move_valid, move_dir        move request, direction; move_ready high only in IDLE
//   map_addr, map_rd_data       map RAM read (data valid the cycle after the address)
//   map_we, map_wr_data         map RAM tile write-back
//   rs_*  (out)                 resolver inputs, live only in RESOLVE
//   rs_*  (in)                  resolver results
//   player_x/y, key_num, health committed player state
//   done, result                one-cycle completion pulse and result code
//                               (0 moved, 1 blocked, 2 edge, 3 cancelled)
//
// Optional: define STEP_COUNT_EN to add step_count[15:0]. It counts successful
// moves, saturates at 16'hFFFF, and clears on init.
module interact_ctrl #(
  parameter int         MAP_W       = interact_ctrl_pkg::MAP_W,
  parameter logic [7:0] HEALTH_INIT = 8'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic [3:0]  init_x,
  input  logic [3:0]  init_y,
  input  logic [7:0]  init_health,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic [7:0]  map_addr,
  input  logic [15:0] map_rd_data,
  output logic        map_we,
  output logic [15:0] map_wr_data,
  output logic [15:0] rs_tile_id,
  output logic [3:0]  rs_pos_x,
  output logic [3:0]  rs_pos_y,
  output logic [3:0]  rs_player_x,
  output logic [3:0]  rs_player_y,
  output logic [3:0]  rs_key_num,
  output logic [7:0]  rs_health,
  input  logic [3:0]  rs_goto_x,
  input  logic [3:0]  rs_goto_y,
  input  logic [3:0]  rs_key_out,
  input  logic [7:0]  rs_health_out,
  input  logic [15:0] rs_new_tile,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic [3:0]  key_num,
  output logic [7:0]  health,
`ifdef STEP_COUNT_EN
  output logic [15:0] step_count,
`endif
  output logic        done,
  output logic [1:0]  result
);
  import interact_ctrl_pkg::*;

  state_t      state_q, state_d;
  result_t     result_q, result_d;
  logic        done_d;
  logic        accept, capture, commit;
  logic        cancel, write_back;

  logic [3:0]  mt_x, mt_y;
  logic        mt_edge;
  logic [7:0]  tgt_addr;

  // Per-move data, meaningful only between accept and commit.
  logic [3:0]  tgt_x, tgt_y;
  logic        edge_q;
  logic [15:0] tile_q, new_tile_q;
  logic [3:0]  goto_x_q, goto_y_q, key_q;
  logic [7:0]  hp_q;

  interact_ctrl_move_target #(.MAP_W(MAP_W)) u_move_target (
    .x       (player_x),
    .y       (player_y),
    .dir     (move_dir),
    .tx      (mt_x),
    .ty      (mt_y),
    .at_edge (mt_edge)
  );

  assign tgt_addr   = 8'((32'(mt_y) * MAP_W) + 32'(mt_x));
  assign move_ready = (state_q == ST_IDLE);
  assign result     = result_q;

  // Cancel when the resolver's key count or health has wrapped.
  assign cancel     = ((key_num == KEY_MAX) && (key_q == 4'd0)) ||
                      ((health >= HEALTH_WRAP_HI) && (hp_q < HEALTH_WRAP_LO));
  assign write_back = (new_tile_q != tile_q);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    commit   = 1'b0;
    if (init) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (move_valid) begin
            accept  = 1'b1;
            state_d = mt_edge ? ST_COMMIT : ST_READ;
          end
        end
        ST_READ:    state_d = ST_RESOLVE;
        ST_RESOLVE: begin
          capture = 1'b1;
          state_d = ST_COMMIT;
        end
        ST_COMMIT: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (edge_q)      result_d = RES_EDGE;
          else if (cancel) result_d = RES_CANCEL;
          else begin
            commit   = 1'b1;
            result_d = ((goto_x_q == player_x) && (goto_y_q == player_y)) ? RES_BLOCKED
                                                                          : RES_MOVED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player_x    <= 4'd0;
      player_y    <= 4'd0;
      key_num     <= 4'd0;
      health      <= HEALTH_INIT;
      done        <= 1'b0;
      result_q    <= RES_MOVED;
      map_we      <= 1'b0;
      map_addr    <= 8'd0;
      map_wr_data <= 16'd0;
    end else begin
      done     <= done_d;
      result_q <= result_d;
      map_we   <= commit && write_back;
      if (commit && write_back) map_wr_data <= new_tile_q;
      // The address stays on the target through commit, so the write-back reuses it.
      if (accept && !mt_edge)   map_addr    <= tgt_addr;
      if (init) begin
        player_x <= init_x;
        player_y <= init_y;
        key_num  <= 4'd0;
        health   <= (init_health == 8'd0) ? HEALTH_INIT : init_health;
      end else if (commit) begin
        player_x <= goto_x_q;
        player_y <= goto_y_q;
        key_num  <= key_q;
        health   <= hp_q;
      end
    end
  end

  // ---- accept / RESOLVE capture stage ----
  always_ff @(posedge clk) begin
    if (accept) begin
      tgt_x  <= mt_x;
      tgt_y  <= mt_y;
      edge_q <= mt_edge;
    end
    if (capture) begin
      tile_q     <= map_rd_data;
      new_tile_q <= rs_new_tile;
      goto_x_q   <= rs_goto_x;
      goto_y_q   <= rs_goto_y;
      key_q      <= rs_key_out;
      hp_q       <= rs_health_out;
    end
  end

  always_comb begin
    rs_player_x = player_x;
    rs_player_y = player_y;
    rs_key_num  = key_num;
    rs_health   = health;
    rs_tile_id  = 16'd0;
    rs_pos_x    = player_x;
    rs_pos_y    = player_y;
    if (state_q == ST_RESOLVE) begin
      rs_tile_id = map_rd_data;
      rs_pos_x   = tgt_x;
      rs_pos_y   = tgt_y;
    end
  end

`ifdef STEP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    step_count <= 16'd0;
    else if (init) step_count <= 16'd0;
    else if (commit && (result_d == RES_MOVED) && (step_count != 16'hFFFF))
      step_count <= step_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_interact_ctrl.sv
// tb_interact_ctrl: scoreboard bench for interact_ctrl.
// It provides a map RAM and a mock tile resolver. Its reference model tracks
// player state and the map as plain variables.
module tb_interact_ctrl;

  localparam logic [15:0] T_GROUND = 16'h0010;
  localparam logic [15:0] T_WALL   = 16'h0020;
  localparam logic [15:0] T_KEY    = 16'h0030;
  localparam logic [15:0] T_POTION = 16'h0040;
  localparam logic [15:0] T_TRAP   = 16'h0050;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic [3:0]  init_x = 4'd0, init_y = 4'd0;
  logic [7:0]  init_health = 8'd0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        move_ready;
  logic [7:0]  map_addr;
  logic [15:0] map_rd_data;
  logic        map_we;
  logic [15:0] map_wr_data;
  logic [15:0] rs_tile_id;
  logic [3:0]  rs_pos_x, rs_pos_y, rs_player_x, rs_player_y, rs_key_num;
  logic [7:0]  rs_health;
  logic [3:0]  rs_goto_x, rs_goto_y, rs_key_out;
  logic [7:0]  rs_health_out;
  logic [15:0] rs_new_tile;
  logic [3:0]  player_x, player_y, key_num;
  logic [7:0]  health;
  logic        done;
  logic [1:0]  result;
`ifdef STEP_COUNT_EN
  logic [15:0] step_count;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  interact_ctrl dut (
    .clk(clk), .rst_n(rst_n), .init(init), .init_x(init_x), .init_y(init_y),
    .init_health(init_health), .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .map_addr(map_addr), .map_rd_data(map_rd_data),
    .map_we(map_we), .map_wr_data(map_wr_data), .rs_tile_id(rs_tile_id),
    .rs_pos_x(rs_pos_x), .rs_pos_y(rs_pos_y), .rs_player_x(rs_player_x),
    .rs_player_y(rs_player_y), .rs_key_num(rs_key_num), .rs_health(rs_health),
    .rs_goto_x(rs_goto_x), .rs_goto_y(rs_goto_y), .rs_key_out(rs_key_out),
    .rs_health_out(rs_health_out), .rs_new_tile(rs_new_tile),
    .player_x(player_x), .player_y(player_y), .key_num(key_num), .health(health),
`ifdef STEP_COUNT_EN
    .step_count(step_count),
`endif
    .done(done), .result(result)
  );

  // Map RAM: synchronous read, loadable from the bench while the DUT is in reset.
  logic [15:0] ram [256];
  logic        fill_en = 1'b0;
  logic [7:0]  fill_addr = 8'd0;
  logic [15:0] fill_data = 16'd0;
  always @(posedge clk) begin
    if (fill_en)     ram[fill_addr] <= fill_data;
    else if (map_we) ram[map_addr]  <= map_wr_data;
    map_rd_data <= ram[map_addr];
  end

  // Mock resolver: walls block, keys add one key, potions add 5 health,
  // traps cost 3 health. Keys and potions leave ground behind.
  typedef struct packed {
    logic [3:0] gx; logic [3:0] gy; logic [3:0] k; logic [7:0] h; logic [15:0] nt;
  } rsv_t;

  function automatic rsv_t resolve(input logic [15:0] t, input logic [3:0] x, input logic [3:0] y,
                                   input logic [3:0] px, input logic [3:0] py,
                                   input logic [3:0] k, input logic [7:0] h);
    rsv_t r;
    r.gx = x; r.gy = y; r.k = k; r.h = h; r.nt = t;
    case (t)
      T_WALL:   begin r.gx = px; r.gy = py; end
      T_KEY:    begin r.k = k + 4'd1; r.nt = T_GROUND; end
      T_POTION: begin r.h = h + 8'd5; r.nt = T_GROUND; end
      T_TRAP:   r.h = h - 8'd3;
      default:  ;
    endcase
    return r;
  endfunction

  rsv_t rv;
  always_comb rv = resolve(rs_tile_id, rs_pos_x, rs_pos_y, rs_player_x, rs_player_y,
                           rs_key_num, rs_health);
  assign rs_goto_x     = rv.gx;
  assign rs_goto_y     = rv.gy;
  assign rs_key_out    = rv.k;
  assign rs_health_out = rv.h;
  assign rs_new_tile   = rv.nt;

  // Reference model state
  logic [15:0] ref_map [256];
  logic [3:0]  mx = 4'd0, my = 4'd0, mk = 4'd0;
  logic [7:0]  mh = 8'd10;
  logic [7:0]  m_addr = 8'd0;

  typedef struct {
    logic [1:0]  res;
    logic [3:0]  px, py, k;
    logic [7:0]  h;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_move(input logic [1:0] d, output exp_t e);
    int nx, ny, a;
    logic [15:0] t;
    rsv_t r;
    nx = int'(mx);
    ny = int'(my);
    case (d)
      2'd0:    ny = ny - 1;
      2'd1:    ny = ny + 1;
      2'd2:    nx = nx - 1;
      default: nx = nx + 1;
    endcase
    e.we = 1'b0;
    e.wdata = 16'd0;
    if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
      e.res = 2'd2;
      e.lat = 1;
    end else begin
      a = ny * 16 + nx;
      m_addr = 8'(a);
      e.lat = 3;
      t = ref_map[a];
      r = resolve(t, 4'(nx), 4'(ny), mx, my, mk, mh);
      if ((mk == 4'd15 && r.k == 4'd0) || (mh >= 8'd251 && r.h < 8'd5)) begin
        e.res = 2'd3;
      end else begin
        e.res = (r.gx == mx && r.gy == my) ? 2'd1 : 2'd0;
        if (r.nt != t) begin
          e.we = 1'b1;
          e.wdata = r.nt;
          ref_map[a] = r.nt;
        end
        mx = r.gx; my = r.gy; mk = r.k; mh = r.h;
      end
    end
    e.px = mx; e.py = my; e.k = mk; e.h = mh;
    e.addr = m_addr;
    e.acc = cyc + 1;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge that shows done.
  task automatic do_move(input logic [1:0] d);
    exp_t e;
    bit got;
    check("idle_ready", 32'(move_ready), 32'd1);
    check("idle_rs_tile", 32'(rs_tile_id), 32'd0);
    model_move(d, e);
    exp_q.push_back(e);
    move_valid = 1'b1;
    move_dir = d;
    @(negedge clk);
    got = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (done) begin got = 1'b1; break; end
      move_valid = 1'($urandom_range(0, 1));
      move_dir = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    move_valid = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done, expected done within 8 cycles");
    end
  endtask

  task automatic do_init(input logic [3:0] x, input logic [3:0] y, input logic [7:0] h,
                         input bit with_move);
    init = 1'b1; init_x = x; init_y = y; init_health = h;
    move_valid = with_move;
    move_dir = 2'($urandom_range(0, 3));
    @(negedge clk);
    init = 1'b0;
    move_valid = 1'b0;
    mx = x; my = y; mk = 4'd0; mh = (h == 8'd0) ? 8'd10 : h;
    check("init_x", 32'(player_x), 32'(mx));
    check("init_y", 32'(player_y), 32'(my));
    check("init_keys", 32'(key_num), 32'(mk));
    check("init_health", 32'(health), 32'(mh));
    check("init_ready", 32'(move_ready), 32'd1);
    check("init_done", 32'(done), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("player_x", 32'(player_x), 32'(e.px));
          check("player_y", 32'(player_y), 32'(e.py));
          check("key_num", 32'(key_num), 32'(e.k));
          check("health", 32'(health), 32'(e.h));
          check("map_we", 32'(map_we), 32'(e.we));
          check("map_addr", 32'(map_addr), 32'(e.addr));
          if (e.we) check("map_wr_data", 32'(map_wr_data), 32'(e.wdata));
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end else if (map_we) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_we: got map_we=1 at addr %0h expected map_we=0", map_addr);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    ref_map[i] = T_WALL;
        2, 3:    ref_map[i] = T_KEY;
        4:       ref_map[i] = T_POTION;
        5:       ref_map[i] = T_TRAP;
        default: ref_map[i] = T_GROUND;
      endcase
    end
    ref_map[68] = T_KEY;                     // (4,4)
    ref_map[52] = T_WALL;                    // (4,3)
    for (int x = 1; x < 16; x++) ref_map[160 + x] = T_KEY;   // row 10
    ref_map[191] = T_KEY;                    // (15,11)
    ref_map[198] = T_POTION;                 // (6,12)
    ref_map[120] = T_GROUND;                 // (8,7)

    @(negedge clk);
    check("rst_player_x", 32'(player_x), 32'd0);
    check("rst_player_y", 32'(player_y), 32'd0);
    check("rst_keys", 32'(key_num), 32'd0);
    check("rst_health", 32'(health), 32'd10);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_we", 32'(map_we), 32'd0);
    check("rst_addr", 32'(map_addr), 32'd0);
    check("rst_wr_data", 32'(map_wr_data), 32'd0);
    check("rst_ready", 32'(move_ready), 32'd1);
    check("rst_rs_tile", 32'(rs_tile_id), 32'd0);

    for (int i = 0; i < 256; i++) begin
      fill_en = 1'b1; fill_addr = 8'(i); fill_data = ref_map[i];
      @(negedge clk);
    end
    fill_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    do_init(4'd3, 4'd4, 8'd0, 1'b0);
    do_move(2'd3);                           // onto key at (4,4)
    do_move(2'd0);                           // into wall at (4,3)
    do_init(4'd0, 4'd7, 8'd0, 1'b1);         // concurrent move must be dropped
    do_move(2'd2);                           // off the left edge

    do_init(4'd0, 4'd10, 8'd0, 1'b0);
    for (int i = 0; i < 15; i++) do_move(2'd3);
    do_move(2'd1);                           // 16th key wraps -> cancel

    do_init(4'd5, 4'd12, 8'd253, 1'b0);
    do_move(2'd3);                           // potion wraps health -> cancel

    // init while a move sits in RESOLVE
    do_init(4'd7, 4'd7, 8'd0, 1'b0);
    move_valid = 1'b1; move_dir = 2'd3; m_addr = 8'd120;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    check("resolve_tile", 32'(rs_tile_id), 32'(ref_map[120]));
    check("resolve_pos_x", 32'(rs_pos_x), 32'd8);
    check("resolve_pos_y", 32'(rs_pos_y), 32'd7);
    do_init(4'd2, 4'd9, 8'd20, 1'b0);
    check("abort_addr", 32'(map_addr), 32'd120);
    repeat (4) begin
      @(negedge clk);
      check("abort_done", 32'(done), 32'd0);
      check("abort_we", 32'(map_we), 32'd0);
    end
    do_move(2'd1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0)
        do_init(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)));
      else
        do_move(2'($urandom_range(0, 3)));
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
